s_16bit_unfold_rx: RTL

Receive-side counterpart of the 16-bit fold stage. The transmitter sends each 16-bit word as its raw high byte followed by the folded byte (low ^ high). This block takes a byte stream carrying one a/b word pair per 4-byte frame, rebuilds both full 16-bit words, and presents them on a valid/ready output register. It sits between the byte link and the 16-bit consumers, and counts framing errors.

---
 rtl/s_16bit_unfold_rx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/s_16bit_unfold_rx.sv
// ---------------------------------------------------------------------------
// s_16bit_unfold_rx
//
// Receive-side unfold stage. The link carries one a/b word pair per 4-byte
// frame in the order a_hi, aa, b_hi, bb, where each folded byte is the low
// byte XORed with its word's high byte. This block rebuilds
//   a = {a_hi, aa ^ a_hi}
//   b = {b_hi, bb ^ b_hi}
// and presents the pair on a valid/ready output register. Framing errors
// (a misplaced or missing frame start) are counted in a saturating counter.
//
// Ports:
//   clk        input   1   single clock, rising edge
//   rst        input   1   asynchronous, active-high reset
//   in_valid   input   1   link byte valid
//   in_ready   output  1   block accepts a byte this cycle
//   in_data    input   8   link byte
//   in_first   input   1   marks a_hi, the first byte of a frame
//   out_valid  output  1   reconstructed pair available
//   out_ready  input   1   consumer accepts the pair
//   a          output 16   reconstructed word a
//   b          output 16   reconstructed word b
//   err_cnt    output  8   saturating framing-error count
// ---------------------------------------------------------------------------
module s_16bit_unfold_rx (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_first,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] a,
    output logic [15:0] b,
    output logic [7:0]  err_cnt
);

    // Position inside the frame: the state names the byte expected next.
    typedef enum logic [1:0] {
        S_AHI = 2'd0,
        S_AA  = 2'd1,
        S_BHI = 2'd2,
        S_BB  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Staging registers for the partially received frame.
    logic [7:0]  r_a_hi;
    logic [7:0]  r_a_lo;
    logic [7:0]  r_b_hi;

    // Output register.
    logic        r_out_valid;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [7:0]  r_err_cnt;

    // Decoded per-cycle strobes.
    logic        w_accept;   // byte handshake this cycle
    logic        w_ld_ahi;   // byte is taken as a_hi (normal or resync)
    logic        w_ld_alo;   // byte is aa in sequence
    logic        w_ld_bhi;   // byte is b_hi in sequence
    logic        w_load;     // byte is bb in sequence: pair completes
    logic        w_drain;    // consumer takes the pending pair
    logic        w_err;      // framing error on this byte

    // -----------------------------------------------------------------------
    // FSM process 1: state register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_AHI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 2: next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (in_first) begin
                // A frame start always restarts the frame, discarding any
                // partial one; from S_AHI this is simply the normal path.
                w_state_nxt = S_AA;
            end else begin
                unique case (r_state)
                    S_AHI:   w_state_nxt = S_AHI;  // stray byte, dropped
                    S_AA:    w_state_nxt = S_BHI;
                    S_BHI:   w_state_nxt = S_BB;
                    S_BB:    w_state_nxt = S_AHI;
                    default: w_state_nxt = S_AHI;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // FSM process 3: outputs and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        in_ready = 1'b1;
        w_accept = 1'b0;
        w_ld_ahi = 1'b0;
        w_ld_alo = 1'b0;
        w_ld_bhi = 1'b0;
        w_load   = 1'b0;
        w_err    = 1'b0;
        w_drain  = r_out_valid && out_ready;

        // Only the completing byte needs a free output register; the first
        // three bytes of the next frame may be staged while a pair waits.
        if (r_state == S_BB && r_out_valid && !out_ready) begin
            in_ready = 1'b0;
        end

        w_accept = in_valid && in_ready;

        if (w_accept) begin
            if (in_first) begin
                w_ld_ahi = 1'b1;
                w_err    = (r_state != S_AHI);
            end else begin
                unique case (r_state)
                    S_AHI:   w_err    = 1'b1;
                    S_AA:    w_ld_alo = 1'b1;
                    S_BHI:   w_ld_bhi = 1'b1;
                    S_BB:    w_load   = 1'b1;
                    default: w_err    = 1'b0;
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Staging registers
    // -----------------------------------------------------------------------
    // The low byte of a is unfolded on arrival, so the completing cycle only
    // has to unfold b.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_hi <= 8'h00;
            r_a_lo <= 8'h00;
            r_b_hi <= 8'h00;
        end else begin
            if (w_ld_ahi) begin
                r_a_hi <= in_data;
            end
            if (w_ld_alo) begin
                r_a_lo <= in_data ^ r_a_hi;
            end
            if (w_ld_bhi) begin
                r_b_hi <= in_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output register
    // -----------------------------------------------------------------------
    // A load wins over a drain in the same cycle, so back-to-back frames keep
    // out_valid high. Data only changes on a load, which holds it stable
    // under backpressure and leaves the last pair visible after a drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
        end else begin
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_a         <= {r_a_hi, r_a_lo};
                r_b         <= {r_b_hi, in_data ^ r_b_hi};
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Framing-error counter, saturating at all ones
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'h00;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign out_valid = r_out_valid;
    assign a         = r_a;
    assign b         = r_b;
    assign err_cnt   = r_err_cnt;

endmodule
